// File: rtl/bist_pkg.sv
// Shared types and constants for the March C- BIST generator: FSM states,
// element indices, data backgrounds and default geometry.
package bist_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 4;
   localparam int MAX_DATA_W = 64;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_M0,
      ST_M1,
      ST_M2,
      ST_M3,
      ST_M4,
      ST_M5,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [2:0] ELEM_M0 = 3'd0;
   localparam logic [2:0] ELEM_M1 = 3'd1;
   localparam logic [2:0] ELEM_M2 = 3'd2;
   localparam logic [2:0] ELEM_M3 = 3'd3;
   localparam logic [2:0] ELEM_M4 = 3'd4;
   localparam logic [2:0] ELEM_M5 = 3'd5;

   // Wide backgrounds; users slice them down to their own DATA_W.
   localparam logic [MAX_DATA_W-1:0] BG_ZERO = '0;
   localparam logic [MAX_DATA_W-1:0] BG_ONE  = '1;

   function automatic logic state_is_elem(input state_t s);
      return (s == ST_M0) || (s == ST_M1) || (s == ST_M2) ||
             (s == ST_M3) || (s == ST_M4) || (s == ST_M5);
   endfunction

   function automatic logic [2:0] state_elem(input state_t s);
      case (s)
         ST_M1:   return ELEM_M1;
         ST_M2:   return ELEM_M2;
         ST_M3:   return ELEM_M3;
         ST_M4:   return ELEM_M4;
         ST_M5:   return ELEM_M5;
         default: return ELEM_M0;
      endcase
   endfunction

   // M1..M4 are read-then-write pairs; M0 and M5 are single-op elements.
   function automatic logic elem_two_op(input logic [2:0] e);
      return (e == ELEM_M1) || (e == ELEM_M2) || (e == ELEM_M3) || (e == ELEM_M4);
   endfunction

   function automatic logic elem_rd_one(input logic [2:0] e);
      return (e == ELEM_M2) || (e == ELEM_M4);
   endfunction

   function automatic logic elem_wr_one(input logic [2:0] e);
      return (e == ELEM_M1) || (e == ELEM_M3);
   endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Up/down march address counter with load-to-0/max, read/write phase bit
// and a flag marking the final operation of the current element.
module march_addr_gen #(
   parameter int ADDR_W = 8
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              load,
   input  logic              load_down,
   input  logic              advance,
   input  logic              two_op,
   output logic [ADDR_W-1:0] addr,
   output logic              phase,
   output logic              last_op
);

   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
   localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              phase_reg, phase_next;
   logic              down_reg, down_next;
   logic [ADDR_W-1:0] term_addr;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         addr_reg  <= ADDR_ZERO;
         phase_reg <= 1'b0;
         down_reg  <= 1'b0;
      end else begin
         addr_reg  <= addr_next;
         phase_reg <= phase_next;
         down_reg  <= down_next;
      end
   end

   // A load always wins over advance so element switches reload instead of wrapping.
   always_comb begin
      addr_next  = addr_reg;
      phase_next = phase_reg;
      down_next  = down_reg;
      if (load) begin
         addr_next  = load_down ? ADDR_MAX : ADDR_ZERO;
         phase_next = 1'b0;
         down_next  = load_down;
      end else if (advance) begin
         if (two_op && !phase_reg) begin
            phase_next = 1'b1;
         end else begin
            phase_next = 1'b0;
            addr_next  = down_reg ? (addr_reg - ADDR_ONE) : (addr_reg + ADDR_ONE);
         end
      end
   end

   assign term_addr = down_reg ? ADDR_ZERO : ADDR_MAX;
   assign addr      = addr_reg;
   assign phase     = phase_reg;
   assign last_op   = (addr_reg == term_addr) && (!two_op || phase_reg);

endmodule

// File: rtl/bist_march_gen.sv
// March C- sequence generator and response checker for the SRAM BIST.
// Define BIST_DIAG_EN to keep first-failure address/element capture.
module bist_march_gen
   import bist_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int READ_LAT = 1
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              Start,
   output logic [ADDR_W-1:0] SRAM_Addr,
   output logic              SRAM_WE,
   output logic [DATA_W-1:0] SRAM_Din,
   input  logic [DATA_W-1:0] SRAM_Dout,
   output logic              Busy,
   output logic              Done,
   output logic              GoNoGo,
   output logic [ADDR_W-1:0] Fail_Addr,
   output logic [2:0]        Fail_Elem
);

   localparam logic [DATA_W-1:0] BG0     = BG_ZERO[DATA_W-1:0];
   localparam logic [DATA_W-1:0] BG1     = BG_ONE[DATA_W-1:0];
   localparam int                DRAIN_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LAT - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

   state_t              state_reg, state_next;
   logic [DRAIN_W-1:0]  drain_cnt_reg;
   logic                fail_reg;

   logic                in_elem;
   logic [2:0]          elem;
   logic                two_op;
   logic                start_accept;
   logic                is_read;
   logic [DATA_W-1:0]   rd_bg;
   logic [DATA_W-1:0]   wr_bg;
   logic                mismatch;

   logic [ADDR_W-1:0]   ag_addr;
   logic                ag_phase;
   logic                ag_last;
   logic                ag_load;
   logic                ag_load_down;

   assign in_elem      = state_is_elem(state_reg);
   assign elem         = state_elem(state_reg);
   assign two_op       = elem_two_op(elem);
   assign start_accept = Start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
   assign is_read      = in_elem && (elem != ELEM_M0) && ((elem == ELEM_M5) || !ag_phase);
   assign rd_bg        = elem_rd_one(elem) ? BG1 : BG0;
   assign wr_bg        = elem_wr_one(elem) ? BG1 : BG0;

   // Reload on start and on every element switch; direction follows the incoming element.
   assign ag_load      = start_accept || (in_elem && ag_last);
   assign ag_load_down = (state_next == ST_M3) || (state_next == ST_M4);

   march_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .load      (ag_load),
      .load_down (ag_load_down),
      .advance   (in_elem),
      .two_op    (two_op),
      .addr      (ag_addr),
      .phase     (ag_phase),
      .last_op   (ag_last)
   );

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: if (Start)   state_next = ST_M0;
         ST_M0:            if (ag_last) state_next = ST_M1;
         ST_M1:            if (ag_last) state_next = ST_M2;
         ST_M2:            if (ag_last) state_next = ST_M3;
         ST_M3:            if (ag_last) state_next = ST_M4;
         ST_M4:            if (ag_last) state_next = ST_M5;
         ST_M5:            if (ag_last) state_next = ST_DRAIN;
         ST_DRAIN:         if (drain_cnt_reg == DRAIN_LAST) state_next = ST_DONE;
         default:          state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      SRAM_Addr = '0;
      SRAM_WE   = 1'b0;
      SRAM_Din  = BG0;
      Busy      = 1'b0;
      Done      = 1'b0;
      GoNoGo    = 1'b0;
      if (in_elem) begin
         SRAM_Addr = ag_addr;
         SRAM_WE   = (elem == ELEM_M0) || (two_op && ag_phase);
         SRAM_Din  = SRAM_WE ? wr_bg : BG0;
         Busy      = 1'b1;
      end else if (state_reg == ST_DRAIN) begin
         Busy      = 1'b1;
      end else if (state_reg == ST_DONE) begin
         Done      = 1'b1;
         GoNoGo    = !fail_reg;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         drain_cnt_reg <= '0;
      end else if (state_reg != ST_DRAIN) begin
         drain_cnt_reg <= '0;
      end else begin
         drain_cnt_reg <= drain_cnt_reg + DRAIN_ONE;
      end
   end

   // Stage 0 is the operation currently on the bus; the last stage lines up with SRAM_Dout.
   logic              cmp_valid_pipe [READ_LAT];
   logic [DATA_W-1:0] cmp_exp_pipe   [READ_LAT];

   assign cmp_valid_pipe[0] = is_read;
   assign cmp_exp_pipe[0]   = rd_bg;

   generate
      for (genvar gi = 1; gi < READ_LAT; gi++) begin : g_cmp_pipe
         always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
               cmp_valid_pipe[gi] <= 1'b0;
               cmp_exp_pipe[gi]   <= '0;
            end else begin
               cmp_valid_pipe[gi] <= cmp_valid_pipe[gi-1];
               cmp_exp_pipe[gi]   <= cmp_exp_pipe[gi-1];
            end
         end
      end
   endgenerate

   assign mismatch = cmp_valid_pipe[READ_LAT-1] && (SRAM_Dout != cmp_exp_pipe[READ_LAT-1]);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         fail_reg <= 1'b0;
      end else if (start_accept) begin
         fail_reg <= 1'b0;
      end else if (mismatch) begin
         fail_reg <= 1'b1;
      end
   end

`ifdef BIST_DIAG_EN
   logic [ADDR_W-1:0] cmp_addr_pipe [READ_LAT];
   logic [2:0]        cmp_elem_pipe [READ_LAT];
   logic [ADDR_W-1:0] fail_addr_reg;
   logic [2:0]        fail_elem_reg;

   assign cmp_addr_pipe[0] = ag_addr;
   assign cmp_elem_pipe[0] = elem;

   generate
      for (genvar gi = 1; gi < READ_LAT; gi++) begin : g_diag_pipe
         always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
               cmp_addr_pipe[gi] <= '0;
               cmp_elem_pipe[gi] <= '0;
            end else begin
               cmp_addr_pipe[gi] <= cmp_addr_pipe[gi-1];
               cmp_elem_pipe[gi] <= cmp_elem_pipe[gi-1];
            end
         end
      end
   endgenerate

   // Only the first mismatch of a run is kept.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         fail_addr_reg <= '0;
         fail_elem_reg <= '0;
      end else if (start_accept) begin
         fail_addr_reg <= '0;
         fail_elem_reg <= '0;
      end else if (mismatch && !fail_reg) begin
         fail_addr_reg <= cmp_addr_pipe[READ_LAT-1];
         fail_elem_reg <= cmp_elem_pipe[READ_LAT-1];
      end
   end

   assign Fail_Addr = fail_addr_reg;
   assign Fail_Elem = fail_elem_reg;
`else
   assign Fail_Addr = '0;
   assign Fail_Elem = '0;
`endif

endmodule

// File: tb/tb_bist_march_gen.sv
// Directed bench for bist_march_gen: READ_LAT=1 and READ_LAT=2 instances,
// each driving a behavioural SRAM with optional stuck-at / coupling faults.
module tb_bist_march_gen;

`ifdef BIST_DIAG_EN
   localparam bit DIAG = 1'b1;
`else
   localparam bit DIAG = 1'b0;
`endif

   logic       Clock;
   logic       Reset_n;

   logic       start_a, we_a, busy_a, done_a, go_a;
   logic [7:0] addr_a, fa_a;
   logic [3:0] din_a, dout_a;
   logic [2:0] fe_a;

   logic       start_b, we_b, busy_b, done_b, go_b;
   logic [7:0] addr_b, fa_b;
   logic [3:0] din_b, dout_b;
   logic [2:0] fe_b;

   logic [3:0] mem_a [256];
   logic [3:0] mem_b [256];
   logic       stuck_a, coup_a, coup_b;

   int checks = 0;
   int errors = 0;

   bist_march_gen #(.ADDR_W(8), .DATA_W(4), .READ_LAT(1)) dut_a (
      .Clock(Clock), .Reset_n(Reset_n), .Start(start_a),
      .SRAM_Addr(addr_a), .SRAM_WE(we_a), .SRAM_Din(din_a), .SRAM_Dout(dout_a),
      .Busy(busy_a), .Done(done_a), .GoNoGo(go_a),
      .Fail_Addr(fa_a), .Fail_Elem(fe_a)
   );

   bist_march_gen #(.ADDR_W(8), .DATA_W(4), .READ_LAT(2)) dut_b (
      .Clock(Clock), .Reset_n(Reset_n), .Start(start_b),
      .SRAM_Addr(addr_b), .SRAM_WE(we_b), .SRAM_Din(din_b), .SRAM_Dout(dout_b),
      .Busy(busy_b), .Done(done_b), .GoNoGo(go_b),
      .Fail_Addr(fa_b), .Fail_Elem(fe_b)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Combinational-read SRAM (one cycle address-to-data) with bit 2 of 0x37 stuck at 0
   // and an idempotent coupling: writing 1s to 0x80 forces 0x7F to 1s.
   assign dout_a = mem_a[addr_a];
   always @(posedge Clock) begin
      if (we_a) begin
         mem_a[addr_a] <= (stuck_a && addr_a == 8'h37) ? (din_a & 4'hB) : din_a;
         if (coup_a && addr_a == 8'h80 && din_a != 4'h0) mem_a[8'h7F] <= 4'hF;
      end
   end

   // Registered-read SRAM for the two-cycle latency instance.
   always @(posedge Clock) begin
      if (we_b) begin
         mem_b[addr_b] <= din_b;
         if (coup_b && addr_b == 8'h80 && din_b != 4'h0) mem_b[8'h7F] <= 4'hF;
      end
      dout_b <= mem_b[addr_b];
   end

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s op=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // Expected {Busy, Addr, WE, Din-if-writing} for 1-based March C- operation k.
   function automatic logic [13:0] exp_op(input int k);
      int j;
      logic [7:0] a;
      logic we;
      logic [3:0] d;
      j = 0; a = 8'h00; we = 1'b0; d = 4'h0;
      if (k <= 256) begin
         a = 8'(k - 1); we = 1'b1; d = 4'h0;
      end else if (k <= 768) begin
         j = k - 257; a = 8'(j / 2); we = j[0]; d = 4'hF;
      end else if (k <= 1280) begin
         j = k - 769; a = 8'(j / 2); we = j[0]; d = 4'h0;
      end else if (k <= 1792) begin
         j = k - 1281; a = 8'(255 - j / 2); we = j[0]; d = 4'hF;
      end else if (k <= 2304) begin
         j = k - 1793; a = 8'(255 - j / 2); we = j[0]; d = 4'h0;
      end else begin
         a = 8'(k - 2305); we = 1'b0;
      end
      if (!we) d = 4'h0;
      return {1'b1, a, we, d};
   endfunction

   // Pulse start on A; returns at the negedge just after start edge E0.
   task automatic start_run_a();
      @(negedge Clock) start_a = 1'b1;
      @(negedge Clock) start_a = 1'b0;
      chk("start_first_op", 1, {18'h0, busy_a, addr_a, we_a, din_a}, {18'h0, 1'b1, 8'h00, 1'b1, 4'h0});
   endtask

   // From the negedge after E0: Done must still be low after E0+2560, high after E0+2561.
   task automatic finish_run_a(input string tag, input logic go, input logic [7:0] fa, input logic [2:0] fe);
      repeat (2560) @(negedge Clock);
      chk({tag, "_pre_done"}, 2560, {30'h0, done_a, busy_a}, {30'h0, 2'b01});
      @(negedge Clock);
      chk({tag, "_done"}, 2561, {29'h0, done_a, busy_a, go_a}, {29'h0, 1'b1, 1'b0, go});
      chk({tag, "_fail_addr"}, 2561, {24'h0, fa_a}, {24'h0, (DIAG ? fa : 8'h00)});
      chk({tag, "_fail_elem"}, 2561, {29'h0, fe_a}, {29'h0, (DIAG ? fe : 3'd0)});
   endtask

   initial begin
      Reset_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      stuck_a = 1'b0; coup_a = 1'b0; coup_b = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 4'h0;
         mem_b[i] = 4'h0;
      end

      // Reset state
      #23;
      chk("reset_a", 0, {3'h0, addr_a, we_a, din_a, busy_a, done_a, go_a, fa_a, fe_a}, 32'h0);
      chk("reset_b", 0, {3'h0, addr_b, we_b, din_b, busy_b, done_b, go_b, fa_b, fe_b}, 32'h0);
      @(negedge Clock) Reset_n = 1'b1;
      repeat (2) @(negedge Clock);

      // Run 1: fault-free, every op checked, stray Start at op 500 must be ignored
      start_a = 1'b1;
      @(negedge Clock) start_a = 1'b0;
      for (int k = 1; k <= 2560; k++) begin
         chk("op", k, {18'h0, busy_a, addr_a, we_a, (we_a ? din_a : 4'h0)}, {18'h0, exp_op(k)});
         start_a = (k == 500);
         @(negedge Clock);
      end
      start_a = 1'b0;
      chk("drain", 2560, {20'h0, busy_a, done_a, we_a, addr_a, 1'b0}, {20'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
      @(negedge Clock);
      chk("run1_done", 2561, {29'h0, done_a, busy_a, go_a}, {29'h0, 3'b101});
      chk("run1_fail_addr", 2561, {24'h0, fa_a}, 32'h0);

      // Start from DONE clears Done/GoNoGo at the next edge; run 2 has a stuck-at bit
      stuck_a = 1'b1;
      start_a = 1'b1;
      @(negedge Clock) start_a = 1'b0;
      chk("restart_clear", 1, {29'h0, done_a, go_a, busy_a}, {29'h0, 3'b001});
      chk("restart_op1", 1, {23'h0, addr_a, we_a}, {23'h0, 8'h00, 1'b1});
      finish_run_a("stuck", 1'b0, 8'h37, 3'd2);

      // Run 3: coupling fault, caught by the descending r0 of M3
      stuck_a = 1'b0;
      coup_a  = 1'b1;
      start_run_a();
      finish_run_a("coupling", 1'b0, 8'h7F, 3'd3);

      // Run 4: reset mid-test (capture already holds the stuck-at failure)
      coup_a  = 1'b0;
      stuck_a = 1'b1;
      start_run_a();
      repeat (999) @(negedge Clock);
      chk("pre_reset_capture", 1000, {23'h0, busy_a, fa_a}, {23'h0, 1'b1, (DIAG ? 8'h37 : 8'h00)});
      #2 Reset_n = 1'b0;
      #1;
      chk("async_reset_a", 1000, {3'h0, addr_a, we_a, din_a, busy_a, done_a, go_a, fa_a, fe_a}, 32'h0);
      repeat (2) @(negedge Clock);
      Reset_n = 1'b1;
      stuck_a = 1'b0;
      repeat (5) @(negedge Clock);
      chk("idle_after_reset", 0, {21'h0, busy_a, done_a, we_a, addr_a}, 32'h0);
      start_run_a();
      finish_run_a("rerun", 1'b1, 8'h00, 3'd0);

      // Run 5: Start held high, a new run begins at the first edge in DONE
      @(negedge Clock) start_a = 1'b1;
      @(negedge Clock);
      finish_run_a("held", 1'b1, 8'h00, 3'd0);
      @(negedge Clock);
      chk("back_to_back", 1, {21'h0, done_a, busy_a, we_a, addr_a}, {21'h0, 1'b0, 1'b1, 1'b1, 8'h00});
      start_a = 1'b0;

      // READ_LAT=2 instance: fault-free, then coupling fault
      for (int r = 0; r < 2; r++) begin
         coup_b = (r == 1);
         @(negedge Clock) start_b = 1'b1;
         @(negedge Clock) start_b = 1'b0;
         chk("rl2_op1", 1, {22'h0, busy_b, addr_b, we_b}, {22'h0, 1'b1, 8'h00, 1'b1});
         @(negedge Clock);
         chk("rl2_op2", 2, {22'h0, busy_b, addr_b, we_b}, {22'h0, 1'b1, 8'h01, 1'b1});
         repeat (2560) @(negedge Clock);
         chk("rl2_pre_done", 2561, {30'h0, done_b, busy_b}, {30'h0, 2'b01});
         @(negedge Clock);
         chk("rl2_done", 2562, {29'h0, done_b, busy_b, go_b}, {29'h0, 1'b1, 1'b0, (r == 0)});
         chk("rl2_fail_addr", 2562, {24'h0, fa_b}, {24'h0, ((DIAG && r == 1) ? 8'h7F : 8'h00)});
         chk("rl2_fail_elem", 2562, {29'h0, fe_b}, {29'h0, ((DIAG && r == 1) ? 3'd3 : 3'd0)});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bist_march_gen.md
# bist_march_gen

March C- test-sequence generator and response checker for the 256x4 SRAM BIST. It replaces the simple incrementing counter as the stage directly upstream of the SRAM. It drives address, write-enable and write data into the SRAM, compares its read data against the expected background, and reports a sticky pass/fail (`GoNoGo`) and `Done`.

## Interface
Parameters:
- `ADDR_W`, default 8: SRAM address width; depth = 2^ADDR_W.
- `DATA_W`, default 4: SRAM word width.
- `READ_LAT`, default 1: SRAM read latency in cycles, from address edge to valid `SRAM_Dout`.

Ports (one clock; reset is asynchronous and active-low):
- `Clock` in 1: sole clock; all state updates on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Start` in 1: begin a test; sampled high on a rising edge.
- `SRAM_Addr` out ADDR_W: SRAM address.
- `SRAM_WE` out 1: 1 = write, 0 = read.
- `SRAM_Din` out DATA_W: write data, all-0s or all-1s background.
- `SRAM_Dout` in DATA_W: SRAM read data.
- `Busy` out 1: test in progress, including the drain cycles.
- `Done` out 1: level; high from test completion until the next accepted `Start` or reset.
- `GoNoGo` out 1: 1 = pass. Valid only while `Done` is high.
- `Fail_Addr` out ADDR_W: address of the first mismatch (diagnostics).
- `Fail_Elem` out 3: march element (0–5) of the first mismatch (diagnostics).

## Operation
- FSM states: IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE.
- March elements:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑(r0)
- ⇑ means address 0 → 2^ADDR_W−1; ⇓ means 2^ADDR_W−1 → 0.
- M1–M4 use a phase bit: a read cycle then a write cycle at the same address, then the address steps.
- Element switch: after the last operation at the terminal address, the next element's first operation is issued the next cycle, with no bubble. The address reloads to 0 or max; it never wraps arithmetically.
- Op count with ADDR_W=8: 256 + 4×512 + 256 = 2560 cycles.
- Expected data for each read = the background of that read (r0 → 0, r1 → all ones). Expected data and a compare-valid bit are pipelined READ_LAT stages to align with `SRAM_Dout`.
- Mismatch = compare-valid & (`SRAM_Dout` != expected). The first mismatch sets sticky fail and captures `Fail_Addr`/`Fail_Elem`. Later mismatches do not overwrite the capture.
- After M5: DRAIN for READ_LAT cycles so pending compares complete; then DONE, with `Done`=1 and `GoNoGo` = !fail.
- `Start` is honoured only in IDLE or DONE. It clears fail, capture, `Done` and `GoNoGo`. `Start` while `Busy` is ignored.
- Outside M0–M5: `SRAM_WE`=0 and `SRAM_Addr` holds 0.

## Timing
- Reset values: `SRAM_Addr`=0, `SRAM_WE`=0, `SRAM_Din`=0, `Busy`=0, `Done`=0, `GoNoGo`=0, `Fail_Addr`=0, `Fail_Elem`=0. Pipeline and FSM go to IDLE.
- Start edge E0: `Busy`=1 and the first M0 write (address 0) are presented after E0.
- Operation k (1-based) is presented in the cycle following edge E0+k−1. Its read data is compared at edge E0+k+READ_LAT−1.
- `Done` rises and `Busy` falls at edge E0 + 2560 + READ_LAT.
- A mismatch whose compare occurs at edge E makes `Fail_Addr` visible after E.
- Reset asserted mid-test: outputs take reset values immediately (asynchronous). The test restarts only on a new `Start`.
- `Start` held high continuously: after DONE, a new test starts at the first edge in DONE (back-to-back runs).

## Configuration
- `BIST_DIAG_EN` defined: first-failure capture logic present; `Fail_Addr`/`Fail_Elem` behave as above.
- Not defined: capture registers are omitted and `Fail_Addr`/`Fail_Elem` are tied to 0. Pass/fail behaviour and timing are identical.

## Structure
- Shared package `bist_pkg`: FSM state enum, element index constants M0–M5, background constants (all-0/all-1 of DATA_W), default ADDR_W/DATA_W.
- Sub-module `march_addr_gen`: up/down address counter with load-to-0/max, phase bit, and terminal-address flag.
- FSM, expected-data pipeline and checker stay in the top.

## Test plan
- Fault-free SRAM model, READ_LAT=1, pulse `Start`:
  - first three cycles: `SRAM_Addr` sequence 0,1,2 with WE=1;
  - M3 begins 1280 ops after Start with address 255 read then write;
  - `Done`=1 at edge E0+2561 with `GoNoGo`=1.
- Stuck-at-0 on bit 2 at address 0x37: `GoNoGo`=0; `Fail_Addr`=0x37, `Fail_Elem`=2 (first r1 read); `Done` timing unchanged.
- Coupling fault (a write of 1 to address 0x80 flips address 0x7F to 1): mismatch detected in M3 (⇓ r0); `Fail_Addr`=0x7F, `Fail_Elem`=3.
- `Reset_n` low at cycle 1000 for 2 cycles: all outputs return to reset values immediately. The block stays idle until `Start`; a rerun passes with the full 2561-cycle timing.
- `Start` pulsed at cycle 500 mid-test: ignored, address sequence undisturbed. `Start` after `Done`: `Done`/`GoNoGo` clear at the next edge and the test reruns.
- READ_LAT=2 build with fault-free model: `Done` at E0+2562, `GoNoGo`=1. With `BIST_DIAG_EN` undefined, `Fail_Addr`=0 even under an injected fault while `GoNoGo`=0.
